// File: rtl/simon_key_schedule_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : simon_key_schedule_ctrl_if
// Description : Command, key-stream and round-key handshake bundle for the
//               Simon key-schedule controller. The master modport is the
//               controller; the slave modport is its environment.
//               Optional stall_cnt bus under SIMON_KEYCTRL_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface simon_key_schedule_ctrl_if;
  logic       start;
  logic       abort;
  logic       key_bit;
  logic       key_valid;
  logic       key_req;
  logic       rk_ready;
  logic       rk_valid;
  logic       data_in;
  logic [1:0] data_rdy;
  logic [5:0] bit_counter;
  logic [6:0] round_idx;
  logic       busy;
  logic       done;
`ifdef SIMON_KEYCTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;

  modport master (
    input  start, abort, key_bit, key_valid, rk_ready,
    output key_req, rk_valid, data_in, data_rdy, bit_counter, round_idx,
           busy, done, stall_cnt
  );
  modport slave (
    output start, abort, key_bit, key_valid, rk_ready,
    input  key_req, rk_valid, data_in, data_rdy, bit_counter, round_idx,
           busy, done, stall_cnt
  );
`else
  modport master (
    input  start, abort, key_bit, key_valid, rk_ready,
    output key_req, rk_valid, data_in, data_rdy, bit_counter, round_idx,
           busy, done
  );
  modport slave (
    output start, abort, key_bit, key_valid, rk_ready,
    input  key_req, rk_valid, data_in, data_rdy, bit_counter, round_idx,
           busy, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/simon_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : simon_key_schedule_ctrl
// Description : Sequencer for the bit-serial Simon key-expansion datapath.
//               Streams KEY_BITS master-key bits in (LOAD), then runs
//               NUM_ROUNDS rounds of 64 bit-cycles (RUN) under back-pressure
//               from the round-key consumer, and pulses done.
//               Optional macro SIMON_KEYCTRL_STALL_CNT_EN adds a saturating
//               16-bit stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 44,
  parameter int KEY_BITS   = 128
) (
  input  logic                      clk,
  input  logic                      reset,   // asynchronous, active-low
  simon_key_schedule_ctrl_if.master bus
);

  localparam int         LOAD_W     = $clog2(KEY_BITS);
  localparam logic [LOAD_W-1:0] LOAD_LAST  = LOAD_W'(KEY_BITS - 1);
  localparam logic [6:0] ROUND_LAST = 7'(NUM_ROUNDS - 1);

  localparam logic [1:0] RDY_CLEAR = 2'd0;
  localparam logic [1:0] RDY_HOLD  = 2'd1;
  localparam logic [1:0] RDY_LOAD  = 2'd2;
  localparam logic [1:0] RDY_RUN   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          round_q, round_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                key_acc;
  logic                rk_acc;
  logic [1:0]          data_rdy;

  // Handshake acceptance and datapath mode code; abort overrides any handshake
  // so the datapath never shifts on the abort cycle.
  always_comb begin
    key_acc  = (state_q == ST_LOAD) && bus.key_valid && !bus.abort;
    rk_acc   = (state_q == ST_RUN)  && bus.rk_ready  && !bus.abort;
    data_rdy = RDY_HOLD;
    case (state_q)
      ST_IDLE: data_rdy = RDY_CLEAR;
      ST_LOAD: data_rdy = key_acc ? RDY_LOAD : RDY_HOLD;
      ST_RUN:  data_rdy = rk_acc  ? RDY_RUN  : RDY_HOLD;
      default: data_rdy = RDY_HOLD;
    endcase
  end

  // Next-state and counter update; leaving for IDLE always clears counters.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    round_d    = round_q;

    if (bus.abort) begin
      state_d    = ST_IDLE;
      load_cnt_d = '0;
      bit_cnt_d  = '0;
      round_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
            bit_cnt_d  = '0;
            round_d    = '0;
          end
        end
        ST_LOAD: begin
          if (key_acc) begin
            load_cnt_d = load_cnt_q + 1'b1;
            bit_cnt_d  = bit_cnt_q + 6'd1;
            if (load_cnt_q == LOAD_LAST) begin
              state_d    = ST_RUN;
              load_cnt_d = '0;
              bit_cnt_d  = '0;
              round_d    = '0;
            end
          end
        end
        ST_RUN: begin
          if (rk_acc) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd63) begin
              if (round_q == ROUND_LAST) begin
                state_d = ST_DONE;
              end else begin
                round_d = round_q + 7'd1;
              end
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          load_cnt_d = '0;
          bit_cnt_d  = '0;
          round_d    = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Controller state and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      bit_cnt_q  <= '0;
      round_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      round_q    <= round_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.key_req     = (state_q == ST_LOAD) && !bus.abort;
  assign bus.rk_valid    = rk_acc;
  assign bus.data_in     = bus.key_bit;
  assign bus.data_rdy    = data_rdy;
  assign bus.bit_counter = bit_cnt_q;
  assign bus.round_idx   = round_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

`ifdef SIMON_KEYCTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall_cyc;

  // Stalls are LOAD cycles without key data and RUN cycles without a taker;
  // the count restarts with each job and saturates.
  always_comb begin
    stall_cyc   = !bus.abort &&
                  (((state_q == ST_LOAD) && !bus.key_valid) ||
                   ((state_q == ST_RUN)  && !bus.rk_ready));
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && bus.start && !bus.abort) begin
      stall_cnt_d = '0;
    end else if (stall_cyc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simon_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_key_schedule_ctrl
// Description : Self-checking bench for simon_key_schedule_ctrl. A job-level
//               model counts accepted bits (adv) and derives phase, bit and
//               round positions arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_key_schedule_ctrl;

  localparam int NR    = 44;
  localparam int KB    = 128;
  localparam int TOTAL = KB + 64 * NR;

  logic clk;
  logic reset;
  simon_key_schedule_ctrl_if bus ();

  simon_key_schedule_ctrl #(.NUM_ROUNDS(NR), .KEY_BITS(KB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: phase 0 = idle, 1 = job in progress, 2 = done cycle
  int phase  = 0;
  int adv    = 0;
  int stalls = 0;

  int  cyc = 0;
  int  start_cyc, done_cyc, cnt2, cnt3, max_rnd, gap_bit_obs;
  bit  done_seen;
  logic kbit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_data_rdy"}, 32'(bus.data_rdy), 0);
    chk({pfx, "_busy"},     32'(bus.busy), 0);
    chk({pfx, "_done"},     32'(bus.done), 0);
    chk({pfx, "_key_req"},  32'(bus.key_req), 0);
    chk({pfx, "_rk_valid"}, 32'(bus.rk_valid), 0);
    chk({pfx, "_bit"},      32'(bus.bit_counter), 0);
    chk({pfx, "_round"},    32'(bus.round_idx), 0);
`ifdef SIMON_KEYCTRL_STALL_CNT_EN
    chk({pfx, "_stall"},    32'(bus.stall_cnt), 0);
`endif
  endtask

  task automatic check_outputs(input bit st, input bit ab, input bit kv, input bit rk);
    int e_rdy, e_kreq, e_rkv, e_busy, e_done, e_bit, e_rnd, r;
    e_rdy = 0; e_kreq = 0; e_rkv = 0; e_busy = 0; e_done = 0; e_bit = 0; e_rnd = 0;
    if (phase == 1) begin
      e_busy = 1;
      if (adv < KB) begin
        e_kreq = ab ? 0 : 1;
        e_rdy  = ab ? 1 : (kv ? 2 : 1);
        e_bit  = adv % 64;
      end else begin
        r     = adv - KB;
        e_bit = r % 64;
        e_rnd = r / 64;
        e_rkv = (rk && !ab) ? 1 : 0;
        e_rdy = ab ? 1 : (rk ? 3 : 1);
      end
    end else if (phase == 2) begin
      e_rdy = 1; e_done = 1; e_rnd = NR - 1;
    end
    chk("data_rdy", 32'(bus.data_rdy), e_rdy);
    chk("key_req",  32'(bus.key_req), e_kreq);
    chk("rk_valid", 32'(bus.rk_valid), e_rkv);
    chk("busy",     32'(bus.busy), e_busy);
    chk("done",     32'(bus.done), e_done);
    chk("bit_counter", 32'(bus.bit_counter), e_bit);
    chk("round_idx",   32'(bus.round_idx), e_rnd);
    chk("data_in",     32'(bus.data_in), 32'(kbit));
`ifdef SIMON_KEYCTRL_STALL_CNT_EN
    chk("stall_cnt", 32'(bus.stall_cnt), (stalls > 65535) ? 65535 : stalls);
`endif
    if (bus.data_rdy == 2'd2) cnt2++;
    if (bus.data_rdy == 2'd3) cnt3++;
    if (int'(bus.round_idx) > max_rnd) max_rnd = int'(bus.round_idx);
    if (bus.done === 1'b1) begin done_seen = 1; done_cyc = cyc; end
    if (phase == 1 && adv < KB && !kv) gap_bit_obs = int'(bus.bit_counter);
  endtask

  task automatic model_step(input bit st, input bit ab, input bit kv, input bit rk);
    if (ab) begin
      phase = 0; adv = 0;
    end else if (phase == 0) begin
      if (st) begin phase = 1; adv = 0; stalls = 0; end
    end else if (phase == 1) begin
      if (adv < KB) begin
        if (kv) adv++; else stalls++;
      end else begin
        if (rk) begin
          adv++;
          if (adv == TOTAL) phase = 2;
        end else stalls++;
      end
    end else begin
      phase = 0; adv = 0;
    end
  endtask

  // Called at posedge+1: drive, check at the falling edge, advance the model.
  task automatic drive_cycle(input bit st, input bit ab, input bit kv, input bit rk);
    kbit          = 1'($urandom_range(0, 1));
    bus.start     = st;
    bus.abort     = ab;
    bus.key_valid = kv;
    bus.rk_ready  = rk;
    bus.key_bit   = kbit;
    #4;
    check_outputs(st, ab, kv, rk);
    @(posedge clk);
    model_step(st, ab, kv, rk);
    cyc++;
    #1;
  endtask

  // One idle cycle with explicit tagged checks of the quiescent outputs.
  task automatic idle_probe(input string pfx);
    bus.start = 0; bus.abort = 0; bus.key_valid = 0; bus.rk_ready = 0;
    #4;
    chk({pfx, "_busy"},     32'(bus.busy), 0);
    chk({pfx, "_data_rdy"}, 32'(bus.data_rdy), 0);
    chk({pfx, "_done"},     32'(bus.done), 0);
    @(posedge clk);
    model_step(0, 0, 0, 0);
    cyc++;
    #1;
  endtask

  task automatic run_job(input int mode, input int abort_adv);
    int gap_k, gap_r;
    bit st, ab, kv, rk, fin;
    gap_k = 0; gap_r = 0; fin = 0;
    cnt2 = 0; cnt3 = 0; max_rnd = 0; done_seen = 0; done_cyc = -1; gap_bit_obs = -1;
    start_cyc = cyc;
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 12000 && !fin; n++) begin
      st = 0; ab = 0; kv = 1; rk = 1;
      if (mode == 1) begin
        if (adv == 70 && gap_k < 5) begin kv = 0; gap_k++; end
        if (adv == KB + 3 * 64 + 63 && gap_r < 2) begin rk = 0; gap_r++; end
      end else if (mode == 2) begin
        kv = ($urandom_range(0, 3) != 0);
        rk = ($urandom_range(0, 3) != 0);
        st = ($urandom_range(0, 31) == 0);
      end
      if (abort_adv >= 0 && phase == 1 && adv == abort_adv) ab = 1;
      drive_cycle(st, ab, kv, rk);
      if (phase == 0) fin = 1;
    end
    chk("job_finished", 32'(fin), 1);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 0; bus.abort = 0; bus.key_bit = 0; bus.key_valid = 0; bus.rk_ready = 0;
    kbit = 0;
    @(posedge clk);
    #2;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Clean job, no stalls.
    run_job(0, -1);
    chk("clean_done_latency", 32'(done_cyc - start_cyc), 2945);
    chk("clean_load_cycles",  32'(cnt2), KB);
    chk("clean_run_cycles",   32'(cnt3), 64 * NR);
    chk("clean_max_round",    32'(max_rnd), NR - 1);

    // Key gap at load bit 70 and round-key stall at round 3 bit 63.
    run_job(1, -1);
    chk("gap_done_latency", 32'(done_cyc - start_cyc), 2945 + 7);
    chk("gap_bit_hold",     32'(gap_bit_obs), 6);
`ifdef SIMON_KEYCTRL_STALL_CNT_EN
    #4;
    chk("gap_stall_total", 32'(bus.stall_cnt), 7);
    #6;
`endif

    // Start together with abort in IDLE is ignored.
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    idle_probe("start_abort_idle");

    // Randomized handshakes with stray start pulses.
    run_job(2, -1);
    chk("random_done_seen", 32'(done_seen), 1);

    // Abort in round 10, then a clean job.
    run_job(0, KB + 10 * 64 + 17);
    chk("abort_no_done", 32'(done_seen), 0);
    idle_probe("abort_idle");
    run_job(0, -1);
    chk("after_abort_latency", 32'(done_cyc - start_cyc), 2945);

    // Asynchronous reset mid-RUN.
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 500; i++) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("pre_areset_busy", 32'(bus.busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("areset");
    phase = 0; adv = 0; stalls = 0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
